// File: rtl/lifo_arb_pkg.sv
// Shared constants for the two-requester LIFO arbiter: op encodings and requester ids.
// Build option LIFO_ARB_FIXED_PRIO_EN (see lifo_rr_arb) selects fixed priority over round-robin.
package lifo_arb_pkg;

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

   typedef logic req_id_t;
   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/lifo_arbiter_if.sv
// Request/response bundle for the two requesters of lifo_arbiter.
// master = requester side, slave = the arbiter.
interface lifo_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             req0_valid;
   logic             req0_op;
   logic [WIDTH-1:0] req0_data;
   logic             req0_ready;
   logic             rsp0_valid;
   logic [WIDTH-1:0] rsp0_data;
   logic             rsp0_err;

   logic             req1_valid;
   logic             req1_op;
   logic [WIDTH-1:0] req1_data;
   logic             req1_ready;
   logic             rsp1_valid;
   logic [WIDTH-1:0] rsp1_data;
   logic             rsp1_err;

   modport master (
      output req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
      input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
      input  req1_ready, rsp1_valid, rsp1_data, rsp1_err
   );

   modport slave (
      input  req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
      output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
      output req1_ready, rsp1_valid, rsp1_data, rsp1_err
   );
endinterface

// File: rtl/lifo_rr_arb.sv
// Two-way grant logic for the LIFO: round-robin on rr_last, or fixed R0 priority
// when LIFO_ARB_FIXED_PRIO_EN is defined. Flush suppresses both grants.
module lifo_rr_arb
   import lifo_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush_i,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);

`ifdef LIFO_ARB_FIXED_PRIO_EN
   logic unused_clk;
   assign unused_clk = clk ^ rst_n;

   always_comb begin
      grant_o    = '0;
      grant_o[0] = !flush_i && valid_i[0];
      grant_o[1] = !flush_i && valid_i[1] && !valid_i[0];
   end
`else
   req_id_t rr_last_q, rr_last_d;

   // Under contention the requester that did not win last time goes first.
   always_comb begin
      grant_o   = '0;
      rr_last_d = rr_last_q;
      if (!flush_i) begin
         grant_o[0] = valid_i[0] && (!valid_i[1] || rr_last_q == REQ1);
         grant_o[1] = valid_i[1] && (!valid_i[0] || rr_last_q == REQ0);
      end
      if (|grant_o) rr_last_d = grant_o[1] ? REQ1 : REQ0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_last_q <= REQ1;
      else        rr_last_q <= rr_last_d;
   end
`endif

endmodule

// File: rtl/lifo_arbiter.sv
// Shared LIFO stack serving two requesters, one push/pop per cycle, registered responses.
// Arbitration policy follows LIFO_ARB_FIXED_PRIO_EN in lifo_rr_arb.
module lifo_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 12,
   parameter int PTR_SZ = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   lifo_arbiter_if.slave     bus,
   output logic [PTR_SZ-1:0] count,
   output logic              empty,
   output logic              full
);

   typedef struct packed {
      logic             valid;
      logic             err;
      logic [WIDTH-1:0] data;
   } rsp_t;

   localparam logic [PTR_SZ-1:0] DEPTH_P = PTR_SZ'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [PTR_SZ-1:0] sp_q, sp_d;
   rsp_t [1:0]        rsp_q, rsp_d;
   logic [1:0]        grant;
   req_id_t           gid;
   logic              accept, op, push_ok, pop_ok;
   logic [WIDTH-1:0]  wdata;

   lifo_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .valid_i ({bus.req1_valid, bus.req0_valid}),
      .grant_o (grant)
   );

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];

   always_comb begin
      accept  = |grant;
      gid     = grant[1] ? REQ1 : REQ0;
      op      = grant[1] ? bus.req1_op : bus.req0_op;
      wdata   = grant[1] ? bus.req1_data : bus.req0_data;
      push_ok = accept && op == OP_PUSH && sp_q != DEPTH_P;
      pop_ok  = accept && op == OP_POP && sp_q != '0;

      sp_d = sp_q;
      if (flush)        sp_d = '0;
      else if (push_ok) sp_d = sp_q + 1'b1;
      else if (pop_ok)  sp_d = sp_q - 1'b1;

      // Rejected ops still answer, with err set and zero data.
      rsp_d = '0;
      if (accept) begin
         rsp_d[gid].valid = 1'b1;
         rsp_d[gid].err   = !(push_ok || pop_ok);
         if (pop_ok) rsp_d[gid].data = mem[sp_q - 1'b1];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[sp_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q  <= '0;
         rsp_q <= '0;
      end else begin
         sp_q  <= sp_d;
         rsp_q <= rsp_d;
      end
   end

   assign bus.rsp0_valid = rsp_q[0].valid;
   assign bus.rsp0_err   = rsp_q[0].err;
   assign bus.rsp0_data  = rsp_q[0].data;
   assign bus.rsp1_valid = rsp_q[1].valid;
   assign bus.rsp1_err   = rsp_q[1].err;
   assign bus.rsp1_data  = rsp_q[1].data;

   assign count = sp_q;
   assign empty = sp_q == '0;
   assign full  = sp_q == DEPTH_P;

endmodule
